tmul_row_drain: RTL

- Downstream drain stage for the FP16 16x32 tile multiplier.
- Tracks each row issued into the 15-register TMUL accumulation chain and captures the 512-bit RowProduct (32 FP16 lanes) in the cycle it is valid.
- Buffers captured rows in a small FIFO and serializes them onto a 64-bit valid/ready stream, 4 lanes per beat.
- Issues credits upstream so that the non-stallable TMUL pipeline can never overrun the buffer.

---
 rtl/tmul_pkg.sv | 15 +
 rtl/tmul_row_fifo.sv | 49 ++++
 rtl/tmul_row_drain.sv | 107 ++++++++++
 3 files changed

// File: rtl/tmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmul_pkg
// Description : Shared constants and row type for the FP16 tile-multiplier drain.
// Revision    : 1.0
// ============================================================================
package tmul_pkg;
    localparam int FP16_W       = 16;
    localparam int ROW_LANES    = 32;
    localparam int ROW_W        = FP16_W * ROW_LANES;
    localparam int TMUL_LATENCY = 15;

    typedef logic [ROW_W-1:0] row_t;
endpackage
`default_nettype wire

// File: rtl/tmul_row_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tmul_row_fifo
// Description : Synchronous row FIFO; pointers reset, storage does not.
// Revision    : 1.0
// ============================================================================
module tmul_row_fifo
    import tmul_pkg::*;
#(
    parameter int WIDTH = $bits(row_t),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW:0]    r_wr;
    logic [C_AW:0]    r_rd;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr[C_AW-1:0]] <= din;
        end
    end

    // One extra pointer bit distinguishes full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop)  r_rd <= r_rd + 1'b1;
        end
    end

    assign head  = r_mem[r_rd[C_AW-1:0]];
    assign empty = (r_wr == r_rd);
    assign full  = (r_wr[C_AW] != r_rd[C_AW]) && (r_wr[C_AW-1:0] == r_rd[C_AW-1:0]);
endmodule
`default_nettype wire

// File: rtl/tmul_row_drain.sv
`default_nettype none
// ============================================================================
// Module      : tmul_row_drain
// Description : Tracks rows through the TMUL chain, buffers them and serializes onto a stream.
// Revision    : 1.0
// ============================================================================
module tmul_row_drain #(
    parameter int ROW_W   = tmul_pkg::ROW_W,
    parameter int OUT_W   = 64,
    parameter int LATENCY = tmul_pkg::TMUL_LATENCY,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     issue_ready,
    input  logic [ROW_W-1:0]         row_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     ovf
);
    import tmul_pkg::*;

    localparam int                C_BEATS     = ROW_W / OUT_W;
    localparam int                C_BEAT_W    = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
    localparam int                C_OCC_W     = $clog2(DEPTH) + 1;
    localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(C_BEATS - 1);
    localparam logic [C_OCC_W-1:0]  C_DEPTH     = C_OCC_W'(DEPTH);

    logic [LATENCY-1:0]  r_vline;
    logic [C_OCC_W-1:0]  r_occ;
    logic                r_ovf;
    logic [C_BEAT_W-1:0] r_beat;
    logic                w_acc;
    logic                w_push;
    logic                w_hs;
    logic                w_pop;
    logic                w_empty;
    logic                w_full;
    logic [ROW_W-1:0]    w_head;

    assign issue_ready = (r_occ < C_DEPTH);
    assign w_acc       = in_valid & issue_ready;

    // Accepted issues ride a delay line that mirrors the TMUL register chain.
    generate
        if (LATENCY == 1) begin : g_vline_single
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_vline <= '0;
                else      r_vline <= w_acc;
            end
        end else begin : g_vline_shift
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_vline <= '0;
                else      r_vline <= {r_vline[LATENCY-2:0], w_acc};
            end
        end
    endgenerate

    assign w_push = r_vline[LATENCY-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_acc && !w_pop)      r_occ <= r_occ + C_OCC_W'(1);
            else if (!w_acc && w_pop) r_occ <= r_occ - C_OCC_W'(1);
            if (in_valid && !issue_ready) r_ovf <= 1'b1;
        end
    end

    assign occupancy = r_occ;
    assign ovf       = r_ovf;

    tmul_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (row_product),
        .pop   (w_pop),
        .head  (w_head),
        .empty (w_empty),
        .full  (w_full)
    );

    assign out_valid = !w_empty;
    assign w_hs      = out_valid & out_ready;
    assign w_pop     = w_hs & (r_beat == C_LAST_BEAT);
    assign out_last  = out_valid & (r_beat == C_LAST_BEAT);
    assign out_data  = out_valid ? w_head[r_beat*OUT_W +: OUT_W] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_beat <= '0;
        else if (w_hs) r_beat <= w_pop ? '0 : r_beat + C_BEAT_W'(1);
    end

    // Credits bound rows in flight plus buffered, so a capture never finds the FIFO full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_push && w_full));
endmodule
`default_nettype wire
